// File: rtl/tsn_sched_pkg.sv
// Shared types and helpers for the TSN ingress read scheduler.
package tsn_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam int PRIO_RUN_W = 8;

   // Ceiling log2, used to size queue-index fields.
   function automatic int log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/tsn_input_scheduler_if.sv
// Scheduler-to-datapath bundle: FIFO status in, pop strobes and mux select out.
interface tsn_input_scheduler_if #(
   parameter int NQ = 7,
   parameter int QW = tsn_sched_pkg::log2(NQ)
);
   logic [NQ-1:0] empty;
   logic [NQ-1:0] head_tlast;
   logic          m_axis_tready;
   logic [NQ-1:0] prio_mask;
   logic [NQ-1:0] port_en;
   logic [NQ-1:0] rd_en;
   logic [QW-1:0] cur_queue;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          pkt_fwd;

   modport master (
      input  empty, head_tlast, m_axis_tready, prio_mask, port_en,
      output rd_en, cur_queue, m_axis_tvalid, m_axis_tlast, pkt_fwd
   );

   modport slave (
      output empty, head_tlast, m_axis_tready, prio_mask, port_en,
      input  rd_en, cur_queue, m_axis_tvalid, m_axis_tlast, pkt_fwd
   );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping NQ-1 -> 0.
module rr_pick
   import tsn_sched_pkg::*;
#(
   parameter int NQ = 7,
   parameter int QW = log2(NQ)
) (
   input  logic [NQ-1:0] req,
   input  logic [QW-1:0] ptr,
   output logic [QW-1:0] gnt_idx,
   output logic          any
);

   logic [QW-1:0] scan_idx;

   always_comb begin
      scan_idx = ptr;
      gnt_idx  = '0;
      any      = 1'b0;
      for (int i = 0; i < NQ; i++) begin
         scan_idx = (scan_idx == QW'(NQ - 1)) ? '0 : scan_idx + 1'b1;
         if (!any && req[scan_idx]) begin
            any     = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

endmodule

// File: rtl/tsn_input_scheduler.sv
// Packet-granular read scheduler: two round-robin classes with a starvation guard
// that forces one best-effort packet after MAX_PRIO_BURST bypassing priority packets.
module tsn_input_scheduler
   import tsn_sched_pkg::*;
#(
   parameter int NUM_QUEUES     = 7,
   parameter int MAX_PRIO_BURST = 4,
   parameter int QW             = log2(NUM_QUEUES)
) (
   input logic                   axis_aclk,
   input logic                   axis_reset,
   tsn_input_scheduler_if.master sif
);

   localparam int NQ = NUM_QUEUES;
   localparam logic [PRIO_RUN_W-1:0] BURST_MAX = PRIO_RUN_W'(MAX_PRIO_BURST);
   localparam int CLS_HP = 0;
   localparam int CLS_BE = 1;

   state_t                  state_reg, state_next;
   logic [QW-1:0]           cur_queue_reg, cur_queue_next;
   logic [QW-1:0]           hp_ptr_reg, hp_ptr_next;
   logic [QW-1:0]           be_ptr_reg, be_ptr_next;
   logic [PRIO_RUN_W-1:0]   prio_run_reg, prio_run_next;
   logic                    pkt_fwd_reg, pkt_fwd_next;

   logic [NQ-1:0]           elig;
   logic [1:0][NQ-1:0]      cls_req;
   logic [1:0][QW-1:0]      cls_ptr;
   logic [1:0][QW-1:0]      cls_idx;
   logic [1:0]              cls_any;
   logic                    beat;

   // Masks are only consumed in IDLE, so mid-packet changes wait for the next grant.
   assign elig            = ~sif.empty & sif.port_en;
   assign cls_req[CLS_HP] = elig & sif.prio_mask;
   assign cls_req[CLS_BE] = elig & ~sif.prio_mask;
   assign cls_ptr[CLS_HP] = hp_ptr_reg;
   assign cls_ptr[CLS_BE] = be_ptr_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_pick
      rr_pick #(.NQ(NQ), .QW(QW)) u_pick (
         .req     (cls_req[gi]),
         .ptr     (cls_ptr[gi]),
         .gnt_idx (cls_idx[gi]),
         .any     (cls_any[gi])
      );
   end

   assign sif.m_axis_tvalid = (state_reg == XFER) && !sif.empty[cur_queue_reg];
   assign sif.m_axis_tlast  = sif.m_axis_tvalid && sif.head_tlast[cur_queue_reg];
   assign sif.cur_queue     = cur_queue_reg;
   assign sif.pkt_fwd       = pkt_fwd_reg;
   assign beat              = sif.m_axis_tvalid && sif.m_axis_tready;

   always_comb begin
      state_next     = state_reg;
      cur_queue_next = cur_queue_reg;
      hp_ptr_next    = hp_ptr_reg;
      be_ptr_next    = be_ptr_reg;
      prio_run_next  = prio_run_reg;
      pkt_fwd_next   = 1'b0;
      sif.rd_en      = '0;
      case (state_reg)
         IDLE: begin
            if (cls_any[CLS_HP] && (!cls_any[CLS_BE] || prio_run_reg < BURST_MAX)) begin
               state_next     = XFER;
               cur_queue_next = cls_idx[CLS_HP];
               hp_ptr_next    = cls_idx[CLS_HP];
               pkt_fwd_next   = 1'b1;
               // Only count priority packets that actually bypassed waiting best-effort work.
               if (cls_any[CLS_BE] && prio_run_reg < BURST_MAX) begin
                  prio_run_next = prio_run_reg + 1'b1;
               end
            end else if (cls_any[CLS_BE]) begin
               state_next     = XFER;
               cur_queue_next = cls_idx[CLS_BE];
               be_ptr_next    = cls_idx[CLS_BE];
               pkt_fwd_next   = 1'b1;
               prio_run_next  = '0;
            end
         end
         XFER: begin
            if (beat) begin
               sif.rd_en[cur_queue_reg] = 1'b1;
               if (sif.head_tlast[cur_queue_reg]) begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk or posedge axis_reset) begin
      if (axis_reset) begin
         state_reg     <= IDLE;
         cur_queue_reg <= '0;
         hp_ptr_reg    <= QW'(NQ - 1);
         be_ptr_reg    <= QW'(NQ - 1);
         prio_run_reg  <= '0;
         pkt_fwd_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cur_queue_reg <= cur_queue_next;
         hp_ptr_reg    <= hp_ptr_next;
         be_ptr_reg    <= be_ptr_next;
         prio_run_reg  <= prio_run_next;
         pkt_fwd_reg   <= pkt_fwd_next;
      end
   end

endmodule

// File: tb/tb_tsn_input_scheduler.sv
// Directed bench: per-queue FIFO stimulus model, grant log, hand-computed expectations.
module tb_tsn_input_scheduler;
   import tsn_sched_pkg::*;

   localparam int NQ  = 7;
   localparam int QW  = 3;
   localparam int MPB = 4;

   logic axis_aclk  = 1'b0;
   logic axis_reset = 1'b1;
   always #5 axis_aclk = ~axis_aclk;

   tsn_input_scheduler_if #(.NQ(NQ), .QW(QW)) sif ();

   tsn_input_scheduler #(
      .NUM_QUEUES     (NQ),
      .MAX_PRIO_BURST (MPB),
      .QW             (QW)
   ) dut (
      .axis_aclk  (axis_aclk),
      .axis_reset (axis_reset),
      .sif        (sif.master)
   );

   int            beats [NQ];
   int            plen [NQ];
   int            delivered [NQ];
   int            grants [NQ];
   logic [NQ-1:0] hold;
   int            pend;
   int            cyc_n;
   int            n_chk;
   int            n_pass;
   bit            tog_en, p5_arm, t1_chk, t4_chk;
   int            glog [$];
   int            gcyc [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   function automatic logic bit_at(input logic [NQ-1:0] v, input int q);
      logic [NQ-1:0] s;
      s = v >> q;
      return s[0];
   endfunction

   function automatic int total_beats();
      int t;
      t = 0;
      for (int q = 0; q < NQ; q++) t += beats[q];
      return t;
   endfunction

   task automatic drive();
      logic [NQ-1:0] e, t;
      e = '0;
      t = '0;
      for (int q = 0; q < NQ; q++) begin
         if (beats[q] == 0 || bit_at(hold, q)) e |= NQ'(1) << q;
         if (beats[q] > 0 && ((beats[q] - 1) % plen[q]) == 0) t |= NQ'(1) << q;
      end
      sif.empty      = e;
      sif.head_tlast = t;
   endtask

   task automatic clear();
      for (int q = 0; q < NQ; q++) begin
         beats[q]     = 0;
         plen[q]      = 1;
         delivered[q] = 0;
         grants[q]    = 0;
      end
      glog.delete();
      gcyc.delete();
   endtask

   // One clock: apply last cycle's pop after the edge, re-drive, then sample at negedge.
   task automatic cyc();
      logic [NQ-1:0] rv;
      int            cq;
      @(posedge axis_aclk);
      #1;
      if (pend >= 0) begin
         beats[pend]--;
         delivered[pend]++;
         pend = -1;
      end
      if (tog_en) sif.m_axis_tready = ~sif.m_axis_tready;
      if (p5_arm && delivered[4] == 2) begin
         sif.port_en[4] = 1'b0;
         p5_arm         = 1'b0;
      end
      drive();
      @(negedge axis_aclk);
      cyc_n++;
      if (sif.pkt_fwd === 1'b1) begin
         cq = int'(sif.cur_queue);
         glog.push_back(cq);
         gcyc.push_back(cyc_n);
         grants[cq]++;
         $display("grant q=%0d cycle=%0d", cq, cyc_n);
      end
      rv = sif.rd_en;
      chk("rd_en_onehot", 32'($countones(rv) <= 1), 1);
      for (int q = 0; q < NQ; q++) begin
         if (bit_at(rv, q)) begin
            chk("pop_nonempty", 32'(bit_at(sif.empty, q)), 0);
            chk("rd_en_tvalid", 32'(sif.m_axis_tvalid), 1);
            chk("tlast", 32'(sif.m_axis_tlast), 32'(bit_at(sif.head_tlast, q)));
            pend = q;
         end
      end
      if (t1_chk) begin
         chk("t1_rd_en", 32'(sif.rd_en), 0);
         chk("t1_tvalid", 32'(sif.m_axis_tvalid), 0);
         chk("t1_pkt_fwd", 32'(sif.pkt_fwd), 0);
      end
      if (t4_chk && (bit_at(sif.empty, 1) || !sif.m_axis_tready))
         chk("t4_stall", 32'(sif.rd_en), 0);
   endtask

   task automatic wait_drained(input string tag, input int maxc);
      int n;
      n = 0;
      while (total_beats() > 0 && n < maxc) begin
         cyc();
         n++;
      end
      repeat (2) cyc();
      if (total_beats() > 0) chk(tag, 32'(total_beats()), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int e2 [4];
      int e3 [10];
      int n;
      n_chk  = 0;
      n_pass = 0;
      cyc_n  = 0;
      pend   = -1;
      hold   = '0;
      tog_en = 0; p5_arm = 0; t1_chk = 0; t4_chk = 0;
      sif.m_axis_tready = 1'b1;
      sif.prio_mask     = '0;
      sif.port_en       = '1;
      clear();
      drive();

      // Reset state
      #1;
      chk("rst_rd_en", 32'(sif.rd_en), 0);
      chk("rst_tvalid", 32'(sif.m_axis_tvalid), 0);
      chk("rst_cur_queue", 32'(sif.cur_queue), 0);
      chk("rst_pkt_fwd", 32'(sif.pkt_fwd), 0);
      repeat (3) @(posedge axis_aclk);
      #1 axis_reset = 1'b0;

      // 1: all empty, nothing happens for 20 cycles
      t1_chk = 1;
      repeat (20) cyc();
      t1_chk = 0;

      // 2: Q2/Q5 best-effort, 3-beat packets
      clear();
      plen[2] = 3; beats[2] = 6;
      plen[5] = 3; beats[5] = 6;
      drive();
      wait_drained("t2_timeout", 60);
      e2 = '{2, 5, 2, 5};
      chk("t2_ngrant", 32'(glog.size()), 4);
      for (int i = 0; i < 4; i++)
         if (i < glog.size()) chk($sformatf("t2_grant%0d", i), 32'(glog[i]), 32'(e2[i]));
      for (int i = 1; i < 4; i++)
         if (i < gcyc.size()) chk($sformatf("t2_period%0d", i), 32'(gcyc[i] - gcyc[i-1]), 4);
      chk("t2_beats_q2", 32'(delivered[2]), 6);
      chk("t2_beats_q5", 32'(delivered[5]), 6);
      chk("t2_pkts_q2", 32'(grants[2]), 2);
      chk("t2_pkts_q5", 32'(grants[5]), 2);

      // 3: starvation guard, Q0 priority backlog vs Q3 best-effort
      clear();
      sif.prio_mask = 7'b0000001;
      beats[0] = 8;
      beats[3] = 2;
      drive();
      wait_drained("t3_timeout", 80);
      e3 = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3};
      chk("t3_ngrant", 32'(glog.size()), 10);
      for (int i = 0; i < 10; i++)
         if (i < glog.size()) chk($sformatf("t3_grant%0d", i), 32'(glog[i]), 32'(e3[i]));
      sif.prio_mask = '0;

      // 4: Q1 stalls on empty and toggling tready
      clear();
      plen[1] = 6; beats[1] = 6;
      tog_en = 1; t4_chk = 1;
      drive();
      n = 0;
      while (grants[1] == 0 && n < 20) begin
         cyc();
         n++;
      end
      if (grants[1] == 0) chk("t4_grant_timeout", 0, 1);
      cyc();
      hold = 7'b0000010;
      repeat (5) cyc();
      hold = '0;
      wait_drained("t4_timeout", 60);
      t4_chk = 0; tog_en = 0;
      sif.m_axis_tready = 1'b1;
      chk("t4_beats", 32'(delivered[1]), 6);
      chk("t4_pkts", 32'(grants[1]), 1);

      // 5: port_en[4] dropped mid-packet
      clear();
      plen[4] = 6; beats[4] = 12;
      drive();
      p5_arm = 1;
      repeat (40) cyc();
      chk("t5_beats_dis", 32'(delivered[4]), 6);
      chk("t5_pkts_dis", 32'(grants[4]), 1);
      sif.port_en = '1;
      wait_drained("t5_timeout", 60);
      chk("t5_beats_en", 32'(delivered[4]), 12);
      chk("t5_pkts_en", 32'(grants[4]), 2);

      // 6: asynchronous reset mid-packet
      clear();
      plen[2] = 4; beats[2] = 4;
      drive();
      n = 0;
      while (grants[2] == 0 && n < 20) begin
         cyc();
         n++;
      end
      if (grants[2] == 0) chk("t6_grant_timeout", 0, 1);
      chk("t6_pre_tvalid", 32'(sif.m_axis_tvalid), 1);
      chk("t6_pre_cur", 32'(sif.cur_queue), 2);
      #2 axis_reset = 1'b1;
      #1;
      chk("t6_rd_en", 32'(sif.rd_en), 0);
      chk("t6_tvalid", 32'(sif.m_axis_tvalid), 0);
      chk("t6_cur_queue", 32'(sif.cur_queue), 0);
      pend = -1;
      clear();
      drive();
      repeat (2) @(posedge axis_aclk);
      #1 axis_reset = 1'b0;
      beats[0] = 1;
      beats[3] = 1;
      drive();
      wait_drained("t6_timeout", 20);
      chk("t6_ngrant", 32'(glog.size()), 2);
      if (glog.size() == 2) begin
         chk("t6_first_after_rst", 32'(glog[0]), 0);
         chk("t6_second_after_rst", 32'(glog[1]), 3);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
